// File: rtl/register_file.sv
// register_file: 32 x 64 LEGv8 register file, XZR hardwired to zero, same-cycle write-to-read bypass
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  Clk,
    input  logic                  ResetL,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    input  logic [ADDR_WIDTH-1:0] RW,
    input  logic [DATA_WIDTH-1:0] BusW,
    input  logic                  RegWr,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // next register contents; the zero entry is tied to a constant so it folds away
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            regs_d[i] = (i == ZERO_REG) ? '0 :
                        (RegWr && RW == ADDR_WIDTH'(i)) ? BusW : regs_q[i];
    end

    // storage, cleared asynchronously while ResetL is low
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // zero register beats bypass, bypass beats stored value; reset forces zero
    always_comb begin
        BusA = (!ResetL || RA == ZR) ? '0 : (RegWr && RW == RA) ? BusW : regs_q[RA];
        BusB = (!ResetL || RB == ZR) ? '0 : (RegWr && RW == RB) ? BusW : regs_q[RB];
    end
endmodule
